// File: rtl/irq_router.sv
// ----------------------------------------------------------------------------
// irq_router
//   Routes tile interrupt requests (maskable channels and one NMI per slot)
//   onto CPU interrupt pins through a programmable route table. At most one
//   source is held active at a time. NMIs win over maskable sources, lowest
//   index wins within a class, and an active NMI is never preempted.
//
// Ports
//   clk            sole clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   cfg_clk        unused; the integrator ties it to clk
//   tile_int_req   level maskable requests, bit = slot*NUM_TILE_INT_CH+ch
//   tile_nmi_req   level NMI request per slot
//   irq_ack        CPU acknowledge strobe
//   cfg_wr_en      route-table write strobe
//   cfg_rd_en      route-table read strobe
//   cfg_addr       route-table address
//   cfg_wdata      write data, only [7] (enable) and [3:0] (pin) are kept
//   cpu_int        CPU maskable interrupt pins
//   cpu_nmi        CPU NMI pins
//   slot_ack       one-hot acknowledge to the slot owning the active INT
//   irq_int_active a maskable source is active
//   irq_int_slot   slot of the active maskable source, 0 when none
//   cfg_rdata      registered route-table read data
// ----------------------------------------------------------------------------
module irq_router #(
    parameter int NUM_SLOTS       = 3,
    parameter int NUM_CPU_INT     = 2,
    parameter int NUM_CPU_NMI     = 1,
    parameter int NUM_TILE_INT_CH = 2,
    parameter int CFG_ADDR_WIDTH  = 8,
    localparam int SLOT_IDX_WIDTH = (NUM_SLOTS <= 1) ? 1 : $clog2(NUM_SLOTS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_clk,
    input  logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0] tile_int_req,
    input  logic [NUM_SLOTS-1:0]                 tile_nmi_req,
    input  logic                                 irq_ack,
    input  logic                                 cfg_wr_en,
    input  logic                                 cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0]            cfg_addr,
    input  logic [31:0]                          cfg_wdata,
    output logic [NUM_CPU_INT-1:0]               cpu_int,
    output logic [NUM_CPU_NMI-1:0]               cpu_nmi,
    output logic [NUM_SLOTS-1:0]                 slot_ack,
    output logic                                 irq_int_active,
    output logic [SLOT_IDX_WIDTH-1:0]            irq_int_slot,
    output logic [31:0]                          cfg_rdata
);

    localparam int NUM_INT   = NUM_SLOTS * NUM_TILE_INT_CH;
    localparam int NUM_ENT   = NUM_INT + NUM_SLOTS;   // INT entries, then NMI entries
    localparam int ENT_IDX_W = (NUM_ENT <= 1) ? 1 : $clog2(NUM_ENT);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_NMI,
        SRC_INT
    } src_kind_e;

    // Route table: enable bit and CPU pin index per entry.
    logic [NUM_ENT-1:0]    en_q;
    logic [3:0]            pin_q [NUM_ENT];

    // Active register: class of the held source plus its route-table address.
    src_kind_e             kind_q, kind_d;
    logic [ENT_IDX_W-1:0]  idx_q,  idx_d;
    logic [31:0]           rdata_q;

    logic [NUM_ENT-1:0]    elig;
    logic                  nmi_any, int_any, held_ok;
    logic [ENT_IDX_W-1:0]  nmi_win, int_win;
    logic                  addr_ok;
    logic [ENT_IDX_W-1:0]  ent_addr;
    logic [3:0]            act_pin;
    logic [SLOT_IDX_WIDTH-1:0] act_slot;

    // Request bits are laid out in the same order as the table entries.
    assign elig     = {tile_nmi_req, tile_int_req} & en_q;
    assign addr_ok  = (cfg_addr < CFG_ADDR_WIDTH'(NUM_ENT));
    assign ent_addr = cfg_addr[ENT_IDX_W-1:0];

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        nmi_any = 1'b0;
        nmi_win = '0;
        int_any = 1'b0;
        int_win = '0;
        // Scan downward so the lowest eligible index is the last one written.
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (elig[NUM_INT + s]) begin
                nmi_any = 1'b1;
                nmi_win = ENT_IDX_W'(NUM_INT + s);
            end
        end
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (elig[i]) begin
                int_any = 1'b1;
                int_win = ENT_IDX_W'(i);
            end
        end

        held_ok = (kind_q != SRC_NONE) && elig[idx_q];
        kind_d  = kind_q;
        idx_d   = idx_q;
        if (!held_ok) begin
            if (nmi_any) begin
                kind_d = SRC_NMI;
                idx_d  = nmi_win;
            end else if (int_any) begin
                kind_d = SRC_INT;
                idx_d  = int_win;
            end else begin
                kind_d = SRC_NONE;
                idx_d  = '0;
            end
        end else if (kind_q == SRC_INT && nmi_any) begin
            // Only an NMI may preempt, and only a maskable source.
            kind_d = SRC_NMI;
            idx_d  = nmi_win;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= '0;
            // NOTE: the route table is a handful of flops and must come out of
            // reset disabled, so it is cleared explicitly, unlike a RAM.
            for (int e = 0; e < NUM_ENT; e++) begin
                pin_q[e] <= '0;
            end
            kind_q  <= SRC_NONE;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            kind_q <= kind_d;
            idx_q  <= idx_d;
            if (cfg_rd_en && addr_ok) begin
                rdata_q <= {24'h0, en_q[ent_addr], 3'b000, pin_q[ent_addr]};
            end else begin
                rdata_q <= '0;
            end
            if (cfg_wr_en && addr_ok) begin
                en_q[ent_addr]  <= cfg_wdata[7];
                pin_q[ent_addr] <= cfg_wdata[3:0];
            end
        end
    end

    assign act_pin  = pin_q[idx_q];
    assign act_slot = SLOT_IDX_WIDTH'(idx_q / ENT_IDX_W'(NUM_TILE_INT_CH));

    // Pin outputs decode the held source's table entry; an out-of-range pin
    // index simply matches nothing while the source still stays held.
    always_comb begin
        cpu_int  = '0;
        cpu_nmi  = '0;
        slot_ack = '0;
        for (int k = 0; k < NUM_CPU_INT; k++) begin
            cpu_int[k] = (kind_q == SRC_INT) && (int'(act_pin) == k);
        end
        for (int k = 0; k < NUM_CPU_NMI; k++) begin
            cpu_nmi[k] = (kind_q == SRC_NMI) && (int'(act_pin) == k);
        end
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_ack[s] = irq_ack && (kind_q == SRC_INT) &&
                          (act_slot == SLOT_IDX_WIDTH'(s));
        end
    end

    assign irq_int_active = (kind_q == SRC_INT);
    assign irq_int_slot   = (kind_q == SRC_INT) ? act_slot : '0;
    assign cfg_rdata      = rdata_q;

    // Inputs that carry no function in this block.
    logic unused_ok;
    assign unused_ok = &{1'b0, cfg_clk, cfg_wdata[31:8], cfg_wdata[6:4]};

endmodule

// File: tb/tb_irq_router.sv
// ----------------------------------------------------------------------------
// tb_irq_router
//   Scoreboard bench for irq_router at default parameters. The driver applies
//   one input vector per cycle, advances a behavioural model of the router at
//   the same edge and pushes the expected outputs; a monitor pops and compares
//   on the falling edge. A directed prologue walks the main routing scenarios,
//   then a randomized phase exercises the rest.
// ----------------------------------------------------------------------------
module tb_irq_router;

    localparam int NS  = 3;
    localparam int NCH = 2;
    localparam int NI  = NS * NCH;
    localparam int NE  = NI + NS;

    logic        clk = 1'b0;
    logic        rst;
    logic [NI-1:0] tile_int_req;
    logic [NS-1:0] tile_nmi_req;
    logic        irq_ack;
    logic        cfg_wr_en;
    logic        cfg_rd_en;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [1:0]  cpu_int;
    logic [0:0]  cpu_nmi;
    logic [NS-1:0] slot_ack;
    logic        irq_int_active;
    logic [1:0]  irq_int_slot;
    logic [31:0] cfg_rdata;

    irq_router dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_clk        (clk),
        .tile_int_req   (tile_int_req),
        .tile_nmi_req   (tile_nmi_req),
        .irq_ack        (irq_ack),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_rd_en      (cfg_rd_en),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cpu_int        (cpu_int),
        .cpu_nmi        (cpu_nmi),
        .slot_ack       (slot_ack),
        .irq_int_active (irq_int_active),
        .irq_int_slot   (irq_int_slot),
        .cfg_rdata      (cfg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    cpu_int;
        logic [0:0]    cpu_nmi;
        logic [NS-1:0] slot_ack;
        logic          act;
        logic [1:0]    slot;
        logic [31:0]   rdata;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model: table as integer arrays, active source as an entry
    // address with -1 meaning none. INT i lives at i, NMI slot s at NI+s.
    int          m_en  [NE];
    int          m_pin [NE];
    int          m_act = -1;
    logic [31:0] m_rdata = '0;

    function automatic bit eligible(int e);
        logic [NE-1:0] req;
        req = {tile_nmi_req, tile_int_req};
        return (req[e] == 1'b1) && (m_en[e] != 0);
    endfunction

    // Advance the model over one rising edge using the inputs the DUT sampled.
    task automatic model_edge();
        int nmi_w, int_w, a;
        if (rst) begin
            for (int e = 0; e < NE; e++) begin
                m_en[e]  = 0;
                m_pin[e] = 0;
            end
            m_act   = -1;
            m_rdata = '0;
            return;
        end
        nmi_w = -1;
        for (int s = 0; s < NS; s++)
            if (nmi_w < 0 && eligible(NI + s)) nmi_w = NI + s;
        int_w = -1;
        for (int i = 0; i < NI; i++)
            if (int_w < 0 && eligible(i)) int_w = i;
        if (m_act < 0 || !eligible(m_act))
            m_act = (nmi_w >= 0) ? nmi_w : int_w;
        else if (m_act < NI && nmi_w >= 0)
            m_act = nmi_w;

        a = int'(cfg_addr);
        if (cfg_rd_en && a < NE)
            m_rdata = {24'h0, (m_en[a] != 0), 3'b000, 4'(m_pin[a])};
        else
            m_rdata = '0;
        if (cfg_wr_en && a < NE) begin
            m_en[a]  = int'(cfg_wdata[7]);
            m_pin[a] = int'(cfg_wdata[3:0]);
        end
    endtask

    function automatic exp_t expected();
        exp_t x;
        x.cpu_int  = '0;
        x.cpu_nmi  = '0;
        x.slot_ack = '0;
        x.act      = 1'b0;
        x.slot     = '0;
        x.rdata    = m_rdata;
        if (m_act >= 0 && m_act < NI) begin
            x.act  = 1'b1;
            x.slot = 2'(m_act / NCH);
            if (m_pin[m_act] < 2) x.cpu_int[m_pin[m_act]] = 1'b1;
            if (irq_ack) x.slot_ack[m_act / NCH] = 1'b1;
        end else if (m_act >= NI) begin
            if (m_pin[m_act] == 0) x.cpu_nmi = 1'b1;
        end
        return x;
    endfunction

    // One cycle: let the edge happen, update the model, drive the next
    // vector and queue what the DUT must show until the next edge.
    task automatic apply(input logic r, input logic [NI-1:0] ireq,
                         input logic [NS-1:0] nreq, input logic ack,
                         input logic wr, input logic rd,
                         input logic [7:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        model_edge();
        #1;
        rst          = r;
        tile_int_req = ireq;
        tile_nmi_req = nreq;
        irq_ack      = ack;
        cfg_wr_en    = wr;
        cfg_rd_en    = rd;
        cfg_addr     = addr;
        cfg_wdata    = wdata;
        sb.push_back(expected());
    endtask

    task automatic req(input logic [NI-1:0] ireq, input logic [NS-1:0] nreq,
                       input logic ack, input int n);
        for (int i = 0; i < n; i++) apply(1'b0, ireq, nreq, ack, 1'b0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic wr_cfg(input logic [7:0] addr, input logic [7:0] data);
        apply(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, addr, {24'h0, data});
    endtask

    task automatic check(input string name, input logic [31:0] act_v,
                         input logic [31:0] exp_v);
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            vectors++;
            check("cpu_int",        32'(cpu_int),        32'(x.cpu_int));
            check("cpu_nmi",        32'(cpu_nmi),        32'(x.cpu_nmi));
            check("slot_ack",       32'(slot_ack),       32'(x.slot_ack));
            check("irq_int_active", 32'(irq_int_active), 32'(x.act));
            check("irq_int_slot",   32'(irq_int_slot),   32'(x.slot));
            check("cfg_rdata",      cfg_rdata,           x.rdata);
        end
    end

    initial begin
        logic [NI-1:0] ireq;
        logic [NS-1:0] nreq;
        rst = 1'b1; tile_int_req = '0; tile_nmi_req = '0; irq_ack = 1'b0;
        cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        apply(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);

        // Basic route, assert then drop.
        wr_cfg(8'd0, 8'h80);
        req(6'b000001, 3'b000, 1'b0, 3);
        req(6'b000000, 3'b000, 1'b0, 2);
        // Pulsed request is lost; held pair, then promotion.
        wr_cfg(8'd2, 8'h81);
        req(6'b000001, 3'b000, 1'b0, 2);
        req(6'b000101, 3'b000, 1'b0, 1);
        req(6'b000001, 3'b000, 1'b0, 1);
        req(6'b000000, 3'b000, 1'b0, 2);
        req(6'b000101, 3'b000, 1'b0, 2);
        req(6'b000100, 3'b000, 1'b0, 2);
        req(6'b000000, 3'b000, 1'b0, 1);
        // NMI wins over a simultaneous INT, INT follows when NMI drops.
        wr_cfg(8'd7, 8'h80);
        req(6'b000001, 3'b010, 1'b0, 2);
        req(6'b000001, 3'b000, 1'b0, 2);
        // NMI preempts an active INT but an active NMI is never preempted.
        req(6'b000001, 3'b010, 1'b1, 2);
        req(6'b000000, 3'b000, 1'b0, 1);
        // Acknowledge does not clear; ack while idle does nothing.
        req(6'b000001, 3'b000, 1'b0, 2);
        req(6'b000001, 3'b000, 1'b1, 1);
        req(6'b000001, 3'b000, 1'b0, 1);
        req(6'b000000, 3'b000, 1'b0, 2);
        req(6'b000000, 3'b000, 1'b1, 1);
        // Out-of-range pin still blocks and still acks.
        wr_cfg(8'd0, 8'h83);
        req(6'b000001, 3'b000, 1'b0, 2);
        req(6'b000101, 3'b000, 1'b1, 2);
        req(6'b000000, 3'b000, 1'b0, 1);
        // Disabled entry is never eligible.
        wr_cfg(8'd2, 8'h00);
        req(6'b000100, 3'b000, 1'b1, 2);
        wr_cfg(8'd0, 8'h80);
        req(6'b000001, 3'b000, 1'b0, 2);
        // Disable while active releases at the following edge.
        apply(1'b0, 6'b000001, '0, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0000_0001);
        req(6'b000001, 3'b000, 1'b0, 2);
        // Read back every entry plus out-of-range addresses.
        for (int a = 0; a < NE + 3; a++)
            apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'(a), 32'h0);
        apply(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 8'd200, 32'h0000_008F);
        apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd200, 32'h0);
        // Reset mid-operation aborts the active source.
        wr_cfg(8'd0, 8'h80);
        req(6'b000001, 3'b000, 1'b0, 2);
        apply(1'b1, 6'b000001, '0, 1'b1, 1'b0, 1'b1, 8'd0, 32'h0);
        req(6'b000001, 3'b000, 1'b1, 2);

        // Randomized phase: slowly toggling requests, sparse config traffic.
        ireq = '0;
        nreq = '0;
        for (int n = 0; n < 3000; n++) begin
            logic        r, wr, rd, ack;
            logic [7:0]  addr, data;
            ireq ^= NI'($urandom & $urandom);
            nreq ^= NS'($urandom & $urandom & $urandom);
            r    = ($urandom_range(0, 199) == 0);
            wr   = ($urandom_range(0, 5) == 0);
            rd   = ($urandom_range(0, 2) == 0);
            ack  = 1'($urandom);
            addr = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, NE + 2));
            data = 8'($urandom);
            if ($urandom_range(0, 3) != 0) data[3:0] = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) data[7]   = 1'b1;
            apply(r, ireq, nreq, ack, wr, rd, addr, {24'($urandom), data});
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
